// File: rtl/overlay_fetch_ctrl.sv
// Overlay frame fetch sequencer: issues Avalon-MM burst reads covering one frame per
// accepted frame start, gated by credits for free space in the downstream pixel FIFO.
module overlay_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h3000_0000,
  parameter int                H_PIXELS   = 1920,
  parameter int                V_PIXELS   = 1080,
  parameter int                BURST_LEN  = 16,
  parameter int                FIFO_DEPTH = 64,
  localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int               BC_W       = $clog2(BURST_LEN) + 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_frame_start,
  input  logic              i_pix_pop,
  input  logic              i_avm_waitrequest,
  input  logic              i_avm_readdatavalid,
  output logic              o_avm_read,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic [BC_W-1:0]   o_avm_burstcount,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_underflow,
  output logic              o_overrun,
  output logic [1:0]        o_dbg_state,
  output logic [CNT_W-1:0]  o_dbg_fifo_cnt,
  output logic [CNT_W-1:0]  o_dbg_outstanding
);

  localparam int TOTAL  = H_PIXELS * V_PIXELS;
  localparam int WL_W   = $clog2(TOTAL + 1);
  localparam int CNT_W1 = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [WL_W-1:0]    r_words_left;
  logic [BC_W-1:0]    r_burst;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_fifo_cnt;
  logic               r_underflow;
  logic               r_overrun;

  logic [BC_W-1:0]    w_burst;
  logic [CNT_W1-1:0]  w_free;
  logic               w_room;
  logic               w_pop_ok;
  logic               w_pop_empty;
  logic               w_start_frame;
  logic               w_latch_burst;
  logic               w_accept;
  logic               w_done;

  // Handshake: a request is a read burst presented while avm_read=1; it is taken on the
  // rising edge where waitrequest=0, and address/burstcount are held until that edge.
  always_comb begin
    w_burst = BC_W'(BURST_LEN);
    if (32'(r_words_left) < 32'(BURST_LEN)) begin
      w_burst = BC_W'(r_words_left);
    end
    w_free      = CNT_W1'(FIFO_DEPTH) - {1'b0, r_outstanding} - {1'b0, r_fifo_cnt};
    w_room      = 32'(w_free) >= 32'(w_burst);
    w_pop_ok    = i_pix_pop && (r_fifo_cnt != '0);
    w_pop_empty = i_pix_pop && (r_fifo_cnt == '0);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_frame = 1'b0;
    w_latch_burst = 1'b0;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_start && i_enable) begin
          w_start_frame = 1'b1;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_words_left == '0) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_room) begin
          w_latch_burst = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!i_avm_waitrequest) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_DRAIN: begin
        if (r_outstanding == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr        <= '0;
      r_words_left  <= '0;
      r_burst       <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_underflow   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_start_frame) begin
        r_addr       <= BASE_ADDR;
        r_words_left <= WL_W'(TOTAL);
      end
      if (w_latch_burst) begin
        r_burst <= w_burst;
      end
      if (w_accept) begin
        r_addr       <= r_addr + (ADDR_W'(r_burst) << 2);
        r_words_left <= r_words_left - WL_W'(r_burst);
      end
      // Credits requested on accept and words returned/popped net out in one update.
      r_outstanding <= r_outstanding + (w_accept ? CNT_W'(r_burst) : '0)
                       - CNT_W'(i_avm_readdatavalid);
      r_fifo_cnt    <= r_fifo_cnt + CNT_W'(i_avm_readdatavalid) - CNT_W'(w_pop_ok);
      if (w_start_frame) begin
        r_underflow <= 1'b0;
      end
      if (w_pop_empty) begin
        r_underflow <= 1'b1;
      end
      if (i_frame_start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_avm_read        = (r_state == ST_REQ);
  assign o_avm_address     = r_addr;
  assign o_avm_burstcount  = r_burst;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_frame_done      = w_done;
  assign o_underflow       = r_underflow;
  assign o_overrun         = r_overrun;
  assign o_dbg_state       = r_state;
  assign o_dbg_fifo_cnt    = r_fifo_cnt;
  assign o_dbg_outstanding = r_outstanding;

endmodule

// File: tb/tb_overlay_fetch_ctrl.sv
// Bench for overlay_fetch_ctrl: a 6x3 frame (18 words) so the last burst is short (2 words),
// behind a 3-cycle-latency slave model, with a burst scoreboard and FIFO/credit model.
module tb_overlay_fetch_ctrl;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          H      = 6;
  localparam int          V      = 3;
  localparam int          BL     = 4;
  localparam int          FD     = 8;
  localparam int          TOTAL  = H * V;
  localparam int          CNT_W  = $clog2(FD + 1);
  localparam int          BC_W   = $clog2(BL) + 1;
  localparam int          W      = ADDR_W + BC_W;
  localparam int          ST_IDLE  = 0;
  localparam int          ST_CHECK = 1;
  localparam int          BURSTS   = (TOTAL + BL - 1) / BL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic pix_pop = 1'b0;
  logic waitreq = 1'b0;
  logic rdv = 1'b0;

  logic              avm_read;
  logic [ADDR_W-1:0] avm_address;
  logic [BC_W-1:0]   avm_burstcount;
  logic              busy;
  logic              frame_done;
  logic              underflow;
  logic              overrun;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  dbg_fifo_cnt;
  logic [CNT_W-1:0]  dbg_outstanding;

  overlay_fetch_ctrl #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .H_PIXELS(H), .V_PIXELS(V),
    .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_frame_start(frame_start),
    .i_pix_pop(pix_pop), .i_avm_waitrequest(waitreq), .i_avm_readdatavalid(rdv),
    .o_avm_read(avm_read), .o_avm_address(avm_address), .o_avm_burstcount(avm_burstcount),
    .o_busy(busy), .o_frame_done(frame_done), .o_underflow(underflow), .o_overrun(overrun),
    .o_dbg_state(dbg_state), .o_dbg_fifo_cnt(dbg_fifo_cnt), .o_dbg_outstanding(dbg_outstanding)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and models
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int sched[$];
  int last_sched  = 0;
  int m_fifo      = 0;
  int m_out       = 0;
  int n_acc       = 0;
  int done_cnt    = 0;
  int frame_words = 0;
  int read_cycles = 0;
  int pop_mode    = 0;
  int pop_force_n = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame();
    int words;
    int bc;
    logic [ADDR_W-1:0] addr;
    words = TOTAL;
    addr  = BASE;
    while (words > 0) begin
      bc = (words >= BL) ? BL : words;
      exp_q.push_back({addr, BC_W'(bc)});
      addr  = addr + ADDR_W'(bc * 4);
      words = words - bc;
    end
    frame_words = 0;
  endtask

  // Slave + FIFO model: decides the inputs seen at the next rising edge.
  task automatic slave_step();
    int e;
    int bc;
    int s;
    logic rdv_now;
    logic pop_now;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    e = cyc + 1;
    if (rst) begin
      sched.delete();
      last_sched = 0;
      m_fifo = 0;
      m_out = 0;
      rdv = 1'b0;
      pix_pop = 1'b0;
      return;
    end
    check("fifo_cnt", dbg_fifo_cnt, m_fifo);
    check("outstanding", dbg_outstanding, m_out);
    if (frame_done) begin
      done_cnt++;
      check("frame_words_at_done", frame_words, TOTAL);
    end
    if (avm_read) read_cycles++;
    if (avm_read && !waitreq) begin
      n_acc++;
      got = {avm_address, avm_burstcount};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("burst_addr_count", got, exp);
      bc = int'(avm_burstcount);
      m_out += bc;
      s = (e + 3 > last_sched) ? e + 3 : last_sched + 1;
      for (int k = 0; k < bc; k++) sched.push_back(s + k);
      if (bc > 0) last_sched = s + bc - 1;
    end
    rdv_now = (sched.size() != 0) && (sched[0] == e);
    if (rdv_now) void'(sched.pop_front());
    pop_now = ((pop_mode != 0) && (m_fifo > 0)) || (pop_force_n > 0);
    if (pop_force_n > 0) pop_force_n--;
    rdv = rdv_now;
    pix_pop = pop_now;
    if (rdv_now) begin
      m_out--;
      frame_words++;
    end
    m_fifo = m_fifo + (rdv_now ? 1 : 0) - ((pop_now && m_fifo > 0) ? 1 : 0);
  endtask

  initial forever begin
    @(negedge clk);
    slave_step();
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic en, input logic push);
    if (en && push) push_frame();
    enable = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 1000 && done_cnt < target; i++) tick();
    repeat (3) tick();
    check("frame_done_count", done_cnt, target);
    check("exp_q_empty", exp_q.size(), 0);
    check("idle_after_done", dbg_state, ST_IDLE);
  endtask

  int base;
  int rd_base;

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_read", avm_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_underflow", underflow, 0);
    check("rst_overrun", overrun, 0);
    check("rst_address", avm_address, 0);
    check("rst_burstcount", avm_burstcount, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick();

    // 1: free-running frame, latency N+2
    pop_mode = 1;
    start_frame(1'b1, 1'b1);
    check("t1_read_n1", avm_read, 0);
    check("t1_busy_n1", busy, 1);
    tick();
    check("t1_read_n2", avm_read, 1);
    check("t1_addr_n2", avm_address, BASE);
    wait_done(1);
    check("t1_underflow", underflow, 0);

    // 2: no pops -> credits stall after 2 bursts; 4 pops release the 3rd
    pop_mode = 0;
    base = n_acc;
    start_frame(1'b1, 1'b1);
    for (int i = 0; i < 100 && !((n_acc - base) >= 2 && m_fifo == FD); i++) tick();
    repeat (10) tick();
    check("t2_bursts_stalled", n_acc - base, 2);
    check("t2_state_check", dbg_state, ST_CHECK);
    check("t2_fifo_full", dbg_fifo_cnt, FD);
    pop_force_n = 4;
    for (int i = 0; i < 50 && (n_acc - base) < 3; i++) tick();
    check("t2_third_burst", n_acc - base, 3);
    pop_mode = 1;
    wait_done(2);

    // 3: waitrequest stall on burst 1
    waitreq = 1'b1;
    base = n_acc;
    start_frame(1'b1, 1'b1);
    for (int i = 0; i < 10 && !avm_read; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_read_held", avm_read, 1);
      check("t3_addr_held", avm_address, BASE);
      check("t3_bc_held", avm_burstcount, BL);
      tick();
    end
    waitreq = 1'b0;
    wait_done(3);
    check("t3_accepts", n_acc - base, BURSTS);

    // 5: underflow while empty, then overrun mid-frame
    pop_mode = 0;
    repeat (2) tick();
    pop_force_n = 1;
    repeat (2) tick();
    check("t5_underflow_set", underflow, 1);
    check("t5_fifo_stays_0", dbg_fifo_cnt, 0);
    pop_mode = 1;
    start_frame(1'b1, 1'b1);
    check("t5_underflow_cleared", underflow, 0);
    repeat (4) tick();
    start_frame(1'b1, 1'b0);
    check("t5_overrun_set", overrun, 1);
    check("t5_busy", busy, 1);
    wait_done(4);
    check("t5_overrun_sticky", overrun, 1);
    check("t5_underflow_clear", underflow, 0);

    // 6: async reset during REQ, then disabled frame start
    waitreq = 1'b1;
    base = n_acc;
    start_frame(1'b1, 1'b1);
    for (int i = 0; i < 10 && !avm_read; i++) tick();
    check("t6_in_req", avm_read, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_read", avm_read, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_address", avm_address, 0);
    exp_q.delete();
    waitreq = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("t6_no_accept", n_acc - base, 0);
    rd_base = read_cycles;
    start_frame(1'b0, 1'b0);
    repeat (30) tick();
    check("t6_disabled_reads", read_cycles - rd_base, 0);
    check("t6_disabled_busy", busy, 0);
    check("t6_disabled_accepts", n_acc - base, 0);
    check("final_done_count", done_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
